// File: rtl/md_issue_ctrl.sv
//==============================================================================
// Module   : md_issue_ctrl
// Purpose  : Pipeline-side controller for the execute-stage multiply/divide
//            unit. Drives the D-stage stall for HI/LO users while the unit
//            is launching or busy. Keeps a shadow countdown of the unit's
//            busy window to check the Start/Busy handshake, and maintains
//            performance counters.
// Ports    : clk, reset (sync, active-high)
//            d_md_op[2:0], d_md_read  - D-stage MD op / mfhi-mflo flag
//            e_md_op[2:0]             - op presented to the MD unit
//            md_start, md_busy        - MD unit handshake
//            req                      - exception/interrupt request
//            stall_md                 - hold D, bubble into E (combinational)
//            md_state[1:0]            - shadow state (0 IDLE, 1 MUL, 2 DIV)
//            sync_err                 - sticky handshake-violation flag
//            stall_cnt[31:0]          - stall cycles, saturating
//            mul_cnt[15:0], div_cnt[15:0] - launches, wrapping
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module md_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  d_md_op,
    input  logic        d_md_read,
    input  logic [2:0]  e_md_op,
    input  logic        md_start,
    input  logic        md_busy,
    input  logic        req,
    output logic        stall_md,
    output logic [1:0]  md_state,
    output logic        sync_err,
    output logic [31:0] stall_cnt,
    output logic [15:0] mul_cnt,
    output logic [15:0] div_cnt
);

    localparam logic [3:0] C_MUL_LAT = 4'd5;
    localparam logic [3:0] C_DIV_LAT = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_rem;
    logic        r_chk_arm;
    logic        r_sync_err;
    logic [31:0] r_stall_cnt;
    logic [15:0] r_mul_cnt;
    logic [15:0] r_div_cnt;

    logic w_d_use;
    logic w_e_mul;
    logic w_e_div;
    logic w_e_launch;
    logic w_exp_busy;
    logic w_violation;

    // Op 7 is reserved and behaves like "none".
    assign w_d_use    = ((d_md_op != 3'd0) && (d_md_op != 3'd7)) || d_md_read;
    assign w_e_mul    = (e_md_op == 3'd1) || (e_md_op == 3'd2);
    assign w_e_div    = (e_md_op == 3'd3) || (e_md_op == 3'd4);
    assign w_e_launch = w_e_mul || w_e_div;

    // Stall follows the unit's real handshake, never the shadow model.
    assign stall_md   = w_d_use && (md_start || md_busy);

    assign w_exp_busy = (r_rem != 4'd0);

    // A launchable op sitting in E with the unit free and no request pending
    // must start; anything else that starts, or starts at a bad time, is a
    // handshake violation.
    assign w_violation = (w_exp_busy != md_busy)
                       || (md_start && md_busy)
                       || (md_start && req)
                       || (md_start && !w_e_launch)
                       || (!md_start && w_e_launch && !md_busy && !req);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rem       <= 4'd0;
            r_chk_arm   <= 1'b0;
            r_sync_err  <= 1'b0;
            r_stall_cnt <= 32'd0;
            r_mul_cnt   <= 16'd0;
            r_div_cnt   <= 16'd0;
        end else begin
            // r_chk_arm is still low during the first cycle after reset,
            // which masks the check for that cycle.
            r_chk_arm <= 1'b1;

            if (md_start && w_e_mul) begin
                r_rem   <= C_MUL_LAT;
                r_state <= ST_MUL;
            end else if (md_start && w_e_div) begin
                r_rem   <= C_DIV_LAT;
                r_state <= ST_DIV;
            end else if (r_rem != 4'd0) begin
                r_rem <= r_rem - 4'd1;
                if (r_rem == 4'd1) begin
                    r_state <= ST_IDLE;
                end
            end

            if (r_chk_arm && w_violation) begin
                r_sync_err <= 1'b1;
            end

            if (stall_md && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end

            if (md_start && w_e_mul) begin
                r_mul_cnt <= r_mul_cnt + 16'd1;
            end
            if (md_start && w_e_div) begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end
        end
    end

    assign md_state  = r_state;
    assign sync_err  = r_sync_err;
    assign stall_cnt = r_stall_cnt;
    assign mul_cnt   = r_mul_cnt;
    assign div_cnt   = r_div_cnt;

endmodule

`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
//==============================================================================
// Module   : tb_md_issue_ctrl
// Purpose  : Directed self-checking bench for md_issue_ctrl. The bench plays
//            the MD unit's Start/Busy handshake and the D-stage operands.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  d_md_op;
    logic        d_md_read;
    logic [2:0]  e_md_op;
    logic        md_start;
    logic        md_busy;
    logic        req;
    logic        stall_md;
    logic [1:0]  md_state;
    logic        sync_err;
    logic [31:0] stall_cnt;
    logic [15:0] mul_cnt;
    logic [15:0] div_cnt;

    int n_total = 0;
    int n_pass  = 0;

    md_issue_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .d_md_op   (d_md_op),
        .d_md_read (d_md_read),
        .e_md_op   (e_md_op),
        .md_start  (md_start),
        .md_busy   (md_busy),
        .req       (req),
        .stall_md  (stall_md),
        .md_state  (md_state),
        .sync_err  (sync_err),
        .stall_cnt (stall_cnt),
        .mul_cnt   (mul_cnt),
        .div_cnt   (div_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle's inputs and let combinational outputs settle.
    task automatic drive(input logic [2:0] dop, input logic drd, input logic [2:0] eop,
                         input logic st, input logic bz, input logic rq);
        d_md_op   = dop;
        d_md_read = drd;
        e_md_op   = eop;
        md_start  = st;
        md_busy   = bz;
        req       = rq;
        #1;
    endtask

    // Launch cycle, busy_len busy cycles, then one release cycle.
    task automatic run_op(input logic [2:0] op, input int lat, input int busy_len,
                          input logic [2:0] dop, input logic drd,
                          input logic exp_stall, input logic [1:0] busy_state);
        drive(dop, drd, op, 1'b1, 1'b0, 1'b0);
        check("launch_stall", {31'd0, stall_md}, {31'd0, exp_stall});
        check("launch_state", {30'd0, md_state}, 32'd0);
        tick();
        for (int i = 1; i <= busy_len; i++) begin
            drive(dop, drd, 3'd0, 1'b0, 1'b1, 1'b0);
            check("busy_stall", {31'd0, stall_md}, {31'd0, exp_stall});
            check("busy_state", {30'd0, md_state}, {30'd0, busy_state});
            tick();
        end
        drive(dop, drd, 3'd0, 1'b0, 1'b0, 1'b0);
        check("release_stall", {31'd0, stall_md}, 32'd0);
        check("release_state", {30'd0, md_state},
              (busy_len == lat) ? 32'd0 : {30'd0, busy_state});
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("rst_state",     {30'd0, md_state}, 32'd0);
        check("rst_sync_err",  {31'd0, sync_err}, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_mul_cnt",   {16'd0, mul_cnt}, 32'd0);
        check("rst_div_cnt",   {16'd0, div_cnt}, 32'd0);
        check("rst_stall_md",  {31'd0, stall_md}, 32'd0);
        reset = 1'b0;
        repeat (6) tick();

        // mult with mfhi/mflo waiting in D: 6 stall cycles
        run_op(3'd1, 5, 5, 3'd0, 1'b1, 1'b1, 2'd1);
        check("t1_stall_cnt", stall_cnt, 32'd6);
        check("t1_mul_cnt",   {16'd0, mul_cnt}, 32'd1);
        check("t1_sync_err",  {31'd0, sync_err}, 32'd0);

        // divu with mtlo in D: 11 stall cycles
        run_op(3'd4, 10, 10, 3'd5, 1'b0, 1'b1, 2'd2);
        check("t2_stall_cnt", stall_cnt, 32'd17);
        check("t2_div_cnt",   {16'd0, div_cnt}, 32'd1);
        check("t2_sync_err",  {31'd0, sync_err}, 32'd0);

        // multu with reserved op 7 in D: no stall
        run_op(3'd2, 5, 5, 3'd7, 1'b0, 1'b0, 2'd1);
        check("t3_stall_cnt", stall_cnt, 32'd17);
        check("t3_mul_cnt",   {16'd0, mul_cnt}, 32'd2);
        check("t3_sync_err",  {31'd0, sync_err}, 32'd0);

        // req holds off a div: no load, no error
        drive(3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1);
        check("t4_req_stall", {31'd0, stall_md}, 32'd0);
        tick();
        check("t4_req_state",    {30'd0, md_state}, 32'd0);
        check("t4_req_sync_err", {31'd0, sync_err}, 32'd0);
        // start while busy: violation
        drive(3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
        tick();
        check("t4_err_set", {31'd0, sync_err}, 32'd1);
        drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (12) tick();
        check("t4_err_sticky", {31'd0, sync_err}, 32'd1);
        check("t4_div_cnt",    {16'd0, div_cnt}, 32'd2);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_rst_sync_err",  {31'd0, sync_err}, 32'd0);
        check("t4_rst_stall_cnt", stall_cnt, 32'd0);
        repeat (3) tick();

        // unit drops busy one cycle early after a mult
        run_op(3'd1, 5, 4, 3'd0, 1'b0, 1'b0, 2'd1);
        check("t5_early_drop", {31'd0, sync_err}, 32'd1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        // div, then reset during its third busy cycle
        drive(3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("t5_rst_state",    {30'd0, md_state}, 32'd0);
        check("t5_rst_sync_err", {31'd0, sync_err}, 32'd0);
        check("t5_rst_div_cnt",  {16'd0, div_cnt}, 32'd0);
        check("t5_rst_mul_cnt",  {16'd0, mul_cnt}, 32'd0);
        repeat (3) tick();
        check("t5_shadow_clear", {31'd0, sync_err}, 32'd0);

        // mul_cnt wrap
        drive(3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        repeat (65535) tick();
        check("wrap_ffff", {16'd0, mul_cnt}, 32'h0000_FFFF);
        tick();
        check("wrap_zero", {16'd0, mul_cnt}, 32'd0);

        // stall_cnt saturation
        drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        check("sat_preload", stall_cnt, 32'hFFFF_FFFE);
        drive(3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("sat_first", stall_cnt, 32'hFFFF_FFFF);
        tick();
        tick();
        check("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
